// File: rtl/dmem_arbiter_ctrl.sv
// rtl/dmem_arbiter_ctrl.sv - two-port round-robin arbiter and access sequencer for the data memory
module dmem_arbiter_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m0_req_valid,
    output logic             m0_req_ready,
    input  logic             m0_req_we,
    input  logic [1:0]       m0_req_size,
    input  logic             m0_req_signed,
    input  logic [DEPTH-1:0] m0_req_addr,
    input  logic [WIDTH-1:0] m0_req_wdata,
    input  logic             m1_req_valid,
    output logic             m1_req_ready,
    input  logic             m1_req_we,
    input  logic [1:0]       m1_req_size,
    input  logic             m1_req_signed,
    input  logic [DEPTH-1:0] m1_req_addr,
    input  logic [WIDTH-1:0] m1_req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic             rsp_err,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic [DEPTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_data_in,
    output logic             mem_wr,
    output logic             mem_rd,
    output logic             mem_one_byte,
    output logic             mem_two_bytes,
    output logic             mem_four_bytes,
    input  logic [WIDTH-1:0] mem_data_out,
    output logic             busy
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_CAP  = 3'd4;
    localparam logic [2:0] S_RESP = 3'd5;

    logic [2:0]       state_q;
    logic             last_q;
    logic             id_q;
    logic             we_q;
    logic [1:0]       size_q;
    logic             sgn_q;
    logic [DEPTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic             err_q;
    logic [WIDTH-1:0] rdata_q;

    logic             idle;
    logic             any_valid;
    logic             grant_id;
    logic             accept;
    logic             sel_we;
    logic [1:0]       sel_size;
    logic             sel_sgn;
    logic [DEPTH-1:0] sel_addr;
    logic [WIDTH-1:0] sel_wdata;
    logic             sel_err;
    logic [WIDTH-1:0] ext_data;
    logic             mem_active;

    // With both ports requesting, the port not granted last wins.
    always_comb begin
        idle      = (state_q == S_IDLE);
        any_valid = m0_req_valid | m1_req_valid;
        grant_id  = (m0_req_valid & m1_req_valid) ? ~last_q : m1_req_valid;
        accept    = idle & any_valid;
        sel_we    = grant_id ? m1_req_we     : m0_req_we;
        sel_size  = grant_id ? m1_req_size   : m0_req_size;
        sel_sgn   = grant_id ? m1_req_signed : m0_req_signed;
        sel_addr  = grant_id ? m1_req_addr   : m0_req_addr;
        sel_wdata = grant_id ? m1_req_wdata  : m0_req_wdata;
        sel_err   = (sel_size == 2'b11)
                  | ((sel_size == 2'b01) & (sel_addr[1:0] == 2'b11))
                  | ((sel_size == 2'b10) & (sel_addr[1:0] != 2'b00));
    end

    assign m0_req_ready = accept & ~grant_id;
    assign m1_req_ready = accept &  grant_id;

    always_comb begin
        case (size_q)
            2'b00:   ext_data = {{(WIDTH-8){sgn_q & mem_data_out[7]}}, mem_data_out[7:0]};
            2'b01:   ext_data = {{(WIDTH-16){sgn_q & mem_data_out[15]}}, mem_data_out[15:0]};
            default: ext_data = mem_data_out;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        id_q    <= grant_id;
                        last_q  <= grant_id;
                        we_q    <= sel_we;
                        size_q  <= sel_size;
                        sgn_q   <= sel_sgn;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        err_q   <= sel_err;
                        rdata_q <= '0;
                        if (sel_err)     state_q <= S_RESP;
                        else if (sel_we) state_q <= S_WR;
                        else             state_q <= S_RD;
                    end
                end
                S_WR:   state_q <= S_RESP;
                S_RD:   state_q <= S_WAIT;
                S_WAIT: state_q <= S_CAP;
                S_CAP: begin
                    rdata_q <= ext_data;
                    state_q <= S_RESP;
                end
                S_RESP: if (rsp_ready) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Address and size stay on the bus from the strobe cycle through capture.
    assign mem_active     = (state_q == S_WR) | (state_q == S_RD) | (state_q == S_WAIT) | (state_q == S_CAP);
    assign mem_addr       = mem_active ? addr_q : '0;
    assign mem_data_in    = (state_q == S_WR) ? wdata_q : '0;
    assign mem_wr         = (state_q == S_WR);
    assign mem_rd         = (state_q == S_RD);
    assign mem_one_byte   = mem_active & (size_q == 2'b00);
    assign mem_two_bytes  = mem_active & (size_q == 2'b01);
    assign mem_four_bytes = mem_active & (size_q == 2'b10);

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = rsp_valid & id_q;
    assign rsp_err   = rsp_valid & err_q;
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign busy      = ~idle;

endmodule

// File: tb/tb_dmem_arbiter_ctrl.sv
// tb/tb_dmem_arbiter_ctrl.sv - randomized self-checking bench for dmem_arbiter_ctrl
module tb_dmem_arbiter_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pvalid;
    logic        p_we   [2];
    logic [1:0]  p_size [2];
    logic        p_sgn  [2];
    logic [15:0] p_addr [2];
    logic [31:0] p_wdata[2];
    logic        rsp_ready;

    logic        m0_req_ready, m1_req_ready;
    logic        rsp_valid, rsp_id, rsp_err;
    logic [31:0] rsp_rdata;
    logic [15:0] mem_addr;
    logic [31:0] mem_data_in;
    logic        mem_wr, mem_rd, mem_one_byte, mem_two_bytes, mem_four_bytes;
    logic [31:0] mem_data_out;
    logic        busy;

    int total = 0;
    int bad   = 0;

    dmem_arbiter_ctrl #(.WIDTH(32), .DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(pvalid[0]), .m0_req_ready(m0_req_ready), .m0_req_we(p_we[0]),
        .m0_req_size(p_size[0]), .m0_req_signed(p_sgn[0]), .m0_req_addr(p_addr[0]),
        .m0_req_wdata(p_wdata[0]),
        .m1_req_valid(pvalid[1]), .m1_req_ready(m1_req_ready), .m1_req_we(p_we[1]),
        .m1_req_size(p_size[1]), .m1_req_signed(p_sgn[1]), .m1_req_addr(p_addr[1]),
        .m1_req_wdata(p_wdata[1]),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_one_byte(mem_one_byte),
        .mem_two_bytes(mem_two_bytes), .mem_four_bytes(mem_four_bytes),
        .mem_data_out(mem_data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory device: byte-addressable, little-endian, two-cycle read latency.
    logic [7:0]  dev_mem [0:65535];
    logic        rd_d1 = 1'b0;
    logic [15:0] addr_d1 = '0;
    logic [31:0] junk = '0;

    always @(posedge clk) junk <= $urandom;

    always @(posedge clk) begin
        if (mem_wr) begin
            dev_mem[mem_addr] <= mem_data_in[7:0];
            if (mem_two_bytes || mem_four_bytes) dev_mem[mem_addr + 16'd1] <= mem_data_in[15:8];
            if (mem_four_bytes) begin
                dev_mem[mem_addr + 16'd2] <= mem_data_in[23:16];
                dev_mem[mem_addr + 16'd3] <= mem_data_in[31:24];
            end
        end
        rd_d1   <= mem_rd;
        addr_d1 <= mem_addr;
        if (rd_d1) begin
            if (mem_four_bytes)
                mem_data_out <= {dev_mem[addr_d1 + 16'd3], dev_mem[addr_d1 + 16'd2],
                                 dev_mem[addr_d1 + 16'd1], dev_mem[addr_d1]};
            else if (mem_two_bytes)
                mem_data_out <= {junk[31:16], dev_mem[addr_d1 + 16'd1], dev_mem[addr_d1]};
            else
                mem_data_out <= {junk[31:8], dev_mem[addr_d1]};
        end else begin
            mem_data_out <= junk ^ 32'hA5A5_5A5A;
        end
    end

    // Reference model: flat byte array plus the round-robin pointer.
    logic [7:0] ref_mem [0:65535];
    int         model_last;

    function automatic void model_req(input logic we, input logic [1:0] size, input logic sgn,
                                      input logic [15:0] addr, input logic [31:0] wdata,
                                      output logic err, output logic [31:0] rdata);
        int nb;
        err = (size == 2'd3) || (size == 2'd1 && addr[1:0] == 2'b11) ||
              (size == 2'd2 && addr[1:0] != 2'b00);
        rdata = 32'h0;
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < nb; i++) ref_mem[addr + 16'(i)] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < nb; i++) rdata[8*i +: 8] = ref_mem[addr + 16'(i)];
                if (sgn && nb < 4 && rdata[8*nb-1])
                    for (int i = nb; i < 4; i++) rdata[8*i +: 8] = 8'hFF;
            end
        end
    endfunction

    task automatic set_req(input int p, input logic we, input logic [1:0] size, input logic sgn,
                           input logic [15:0] addr, input logic [31:0] wdata);
        p_we[p] = we; p_size[p] = size; p_sgn[p] = sgn; p_addr[p] = addr; p_wdata[p] = wdata;
    endtask

    task automatic rand_req(input int p);
        logic [1:0]  sz;
        logic [15:0] a;
        sz = 2'($urandom_range(0, 3));
        a  = 16'h0040 + 16'($urandom_range(0, 31));
        if ($urandom_range(0, 2) != 0) a = a & ~16'(sz == 2'd2 ? 3 : sz == 2'd1 ? 1 : 0);
        set_req(p, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    endtask

    // Results of the last issued transaction.
    int          o_g, o_lat, o_wr, o_rd;
    logic        o_id, o_err;
    logic [31:0] o_rdata, o_wdata;
    logic [15:0] o_addr;

    task automatic issue(input logic [1:0] mask);
        @(posedge clk); #1;
        pvalid = mask;
        o_g = -1; o_lat = -1; o_wr = 0; o_rd = 0; o_addr = '0; o_wdata = '0;
        o_id = 1'b0; o_err = 1'b0; o_rdata = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m0_req_ready) begin o_g = 0; break; end
            if (m1_req_ready) begin o_g = 1; break; end
        end
        if (o_g < 0) begin
            pvalid = 2'b00;
            return;
        end
        @(posedge clk); #1;
        pvalid = 2'b00;
        rand_req(0);
        rand_req(1);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem_wr) begin o_wr++; o_addr = mem_addr; o_wdata = mem_data_in; end
            if (mem_rd) begin o_rd++; o_addr = mem_addr; end
            if (rsp_valid) begin
                o_lat = k; o_id = rsp_id; o_err = rsp_err; o_rdata = rsp_rdata;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_last = 1;
    endtask

    task automatic test_reset();
        total++;
        if ({busy, rsp_valid, rsp_err, rsp_id, mem_wr, mem_rd, mem_one_byte, mem_two_bytes,
             mem_four_bytes, m0_req_ready, m1_req_ready} !== 11'd0 || rsp_rdata !== 32'h0 ||
            mem_addr !== 16'h0 || mem_data_in !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%0b rsp_valid=%0b mem_addr=%h rdata=%h, all must be 0",
                     busy, rsp_valid, mem_addr, rsp_rdata);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || m0_req_ready !== 1'b0 || m1_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy=%0b rdy0=%0b rdy1=%0b, required 0 0 0",
                     busy, m0_req_ready, m1_req_ready);
        end
    endtask

    task automatic test_store_load();
        logic        e_err;
        logic [31:0] e_rd;
        logic [31:0] req_rd [3];
        logic [15:0] la [3];
        logic [1:0]  ls [3];
        logic        lsg [3];
        req_rd[0] = 32'hFFFF_FFDE; la[0] = 16'h0013; ls[0] = 2'd0; lsg[0] = 1'b1;
        req_rd[1] = 32'h0000_DEAD; la[1] = 16'h0012; ls[1] = 2'd1; lsg[1] = 1'b0;
        req_rd[2] = 32'hFFFF_FFEF; la[2] = 16'h0010; ls[2] = 2'd0; lsg[2] = 1'b1;
        set_req(0, 1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEAD_BEEF);
        model_req(1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEAD_BEEF, e_err, e_rd);
        issue(2'b01);
        model_last = 0;
        total++;
        if (o_lat !== 2 || o_err !== 1'b0 || o_wr !== 1 || o_addr !== 16'h0010 ||
            o_wdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL store_word: lat=%0d err=%0b wr=%0d addr=%h wdata=%h, required 2 0 1 0010 deadbeef",
                     o_lat, o_err, o_wr, o_addr, o_wdata);
        end
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1'b0, ls[i], lsg[i], la[i], 32'h0);
            model_req(1'b0, ls[i], lsg[i], la[i], 32'h0, e_err, e_rd);
            issue(2'b01);
            total++;
            if (o_lat !== 4 || o_err !== 1'b0 || o_rdata !== req_rd[i] || o_rdata !== e_rd ||
                o_rd !== 1 || o_wr !== 0) begin
                bad++;
                $display("FAIL load_%0d: lat=%0d err=%0b rdata=%h rd=%0d, required 4 0 %h 1",
                         i, o_lat, o_err, o_rdata, o_rd, req_rd[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic        ew [3];
        logic [1:0]  es [3];
        logic [15:0] ea [3];
        ew[0] = 1'b0; es[0] = 2'd2; ea[0] = 16'h0011;
        ew[1] = 1'b1; es[1] = 2'd1; ea[1] = 16'h0013;
        ew[2] = 1'b0; es[2] = 2'd3; ea[2] = 16'h0020;
        for (int i = 0; i < 3; i++) begin
            set_req(0, ew[i], es[i], 1'b1, ea[i], 32'h1234_5678);
            issue(2'b01);
            total++;
            if (o_lat !== 1 || o_err !== 1'b1 || o_rdata !== 32'h0 || o_wr !== 0 || o_rd !== 0) begin
                bad++;
                $display("FAIL error_%0d: lat=%0d err=%0b rdata=%h wr=%0d rd=%0d, required 1 1 0 0 0",
                         i, o_lat, o_err, o_rdata, o_wr, o_rd);
            end
        end
    endtask

    task automatic test_round_robin();
        logic        e_err;
        logic [31:0] e_rd;
        int          g;
        do_reset();
        @(posedge clk); #1;
        set_req(0, 1'b0, 2'd2, 1'b0, 16'h0010, 32'h0);
        set_req(1, 1'b1, 2'd0, 1'b0, 16'h0200, 32'h0000_005A);
        pvalid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            g = -1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (m0_req_ready) begin g = 0; break; end
                if (m1_req_ready) begin g = 1; break; end
            end
            model_req(p_we[t%2], p_size[t%2], p_sgn[t%2], p_addr[t%2], p_wdata[t%2], e_err, e_rd);
            total++;
            if (g !== t % 2) begin
                bad++;
                $display("FAIL rr_grant_%0d: granted=%0d, required %0d", t, g, t % 2);
            end
            o_lat = -1;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (rsp_valid) begin
                    o_lat = k; o_id = rsp_id; o_rdata = rsp_rdata;
                    break;
                end
            end
            total++;
            if (o_lat < 0 || o_id !== 1'(t % 2) || o_rdata !== e_rd) begin
                bad++;
                $display("FAIL rr_rsp_%0d: lat=%0d id=%0b rdata=%h, required id=%0d rdata=%h",
                         t, o_lat, o_id, o_rdata, t % 2, e_rd);
            end
        end
        @(posedge clk); #1 pvalid = 2'b00;
        model_last = 1;
        total++;
        if (dev_mem[16'h0200] !== 8'h5A) begin
            bad++;
            $display("FAIL rr_store: mem[0200]=%h, required 5a", dev_mem[16'h0200]);
        end
    endtask

    task automatic test_backpressure();
        logic        e_err;
        logic [31:0] e_rd;
        logic [31:0] s_rd;
        logic        s_id, s_err;
        set_req(1, 1'b0, 2'd2, 1'b0, 16'h0010, 32'h0);
        model_req(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, e_err, e_rd);
        rsp_ready = 1'b0;
        issue(2'b10);
        model_last = 1;
        total++;
        if (o_lat !== 4 || o_rdata !== e_rd || o_id !== 1'b1) begin
            bad++;
            $display("FAIL bp_first: lat=%0d rdata=%h id=%0b, required 4 %h 1", o_lat, o_rdata, o_id, e_rd);
        end
        s_rd = rsp_rdata; s_id = rsp_id; s_err = rsp_err;
        pvalid = 2'b11;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== s_rd || rsp_id !== s_id || rsp_err !== s_err ||
                m0_req_ready !== 1'b0 || m1_req_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold_%0d: valid=%0b rdata=%h rdy0=%0b rdy1=%0b, required 1 %h 0 0",
                         c, rsp_valid, rsp_rdata, m0_req_ready, m1_req_ready, s_rd);
            end
        end
        rsp_ready = 1'b1;
        pvalid = 2'b00;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: valid=%0b busy=%0b, required 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_reset_during_load();
        logic        e_err;
        logic [31:0] e_rd;
        set_req(0, 1'b0, 2'd2, 1'b0, 16'h0010, 32'h0);
        @(posedge clk); #1 pvalid = 2'b01;
        for (int i = 0; i < 20 && !m0_req_ready; i++) @(negedge clk);
        @(posedge clk); #1 pvalid = 2'b00;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b1 || mem_four_bytes !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre: busy=%0b size4=%0b, required 1 1", busy, mem_four_bytes);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({busy, rsp_valid, rsp_err, rsp_id, mem_wr, mem_rd, mem_one_byte, mem_two_bytes,
             mem_four_bytes, m0_req_ready, m1_req_ready} !== 11'd0 || rsp_rdata !== 32'h0 ||
            mem_addr !== 16'h0 || mem_data_in !== 32'h0) begin
            bad++;
            $display("FAIL rst_async: busy=%0b mem_addr=%h size4=%0b, all must be 0",
                     busy, mem_addr, mem_four_bytes);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        model_last = 1;
        set_req(0, 1'b0, 2'd0, 1'b1, 16'h0013, 32'h0);
        set_req(1, 1'b0, 2'd1, 1'b0, 16'h0012, 32'h0);
        model_req(1'b0, 2'd0, 1'b1, 16'h0013, 32'h0, e_err, e_rd);
        issue(2'b11);
        model_last = 0;
        total++;
        if (o_g !== 0 || o_lat !== 4 || o_rdata !== 32'hFFFF_FFDE || o_rdata !== e_rd || o_id !== 1'b0) begin
            bad++;
            $display("FAIL rst_after: grant=%0d lat=%0d rdata=%h id=%0b, required 0 4 ffffffde 0",
                     o_g, o_lat, o_rdata, o_id);
        end
    endtask

    task automatic test_random();
        int          mode, eg, elat;
        logic        e_we, e_err, e_sgn;
        logic [1:0]  e_size;
        logic [15:0] e_addr;
        logic [31:0] e_wd, e_rd;
        for (int n = 0; n < 40; n++) begin
            mode = $urandom_range(0, 2);
            rand_req(0);
            rand_req(1);
            eg = (mode == 2) ? ((model_last == 1) ? 0 : 1) : mode;
            e_we = p_we[eg]; e_size = p_size[eg]; e_sgn = p_sgn[eg];
            e_addr = p_addr[eg]; e_wd = p_wdata[eg];
            model_req(e_we, e_size, e_sgn, e_addr, e_wd, e_err, e_rd);
            elat = e_err ? 1 : (e_we ? 2 : 4);
            issue(mode == 0 ? 2'b01 : mode == 1 ? 2'b10 : 2'b11);
            model_last = eg;
            total++;
            if (o_g !== eg || o_id !== 1'(eg)) begin
                bad++;
                $display("FAIL rnd_grant_%0d: grant=%0d id=%0b, required %0d", n, o_g, o_id, eg);
            end
            total++;
            if (o_lat !== elat || o_err !== e_err || o_rdata !== e_rd) begin
                bad++;
                $display("FAIL rnd_rsp_%0d: lat=%0d err=%0b rdata=%h, required %0d %0b %h",
                         n, o_lat, o_err, o_rdata, elat, e_err, e_rd);
            end
            total++;
            if (o_wr !== int'(!e_err && e_we) || o_rd !== int'(!e_err && !e_we) ||
                (!e_err && o_addr !== e_addr) || (!e_err && e_we && o_wdata !== e_wd)) begin
                bad++;
                $display("FAIL rnd_mem_%0d: wr=%0d rd=%0d addr=%h wdata=%h, required addr=%h wdata=%h",
                         n, o_wr, o_rd, o_addr, o_wdata, e_addr, e_wd);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        rsp_ready = 1'b1;
        pvalid = 2'b00;
        for (int p = 0; p < 2; p++) set_req(p, 1'b0, 2'd0, 1'b0, 16'h0, 32'h0);
        for (int i = 0; i < 65536; i++) begin
            dev_mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        model_last = 1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_store_load();
        test_errors();
        test_round_robin();
        test_backpressure();
        test_reset_during_load();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
